// File: rtl/vid_in_pkg.sv
// -----------------------------------------------------------------------------
// vid_in_pkg
// Shared definitions for the video-in to AXI4-Stream bridge:
//   - vid_state_e      : bridge FSM states
//   - FIFO_AW          : FIFO address width for the default 1024-entry build
//   - SOF_BIT/EOL_BIT  : flag positions above the pixel field of a FIFO word
//   - fifo_word_width  : FIFO word width for a given pixel width
// -----------------------------------------------------------------------------
package vid_in_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_SYNC    = 2'd1,
    ST_RUN     = 2'd2,
    ST_DROP    = 2'd3
  } vid_state_e;

  // Address width of the default-depth FIFO; other depths derive their own.
  localparam int FIFO_AW = 10;

  // A FIFO word is {sof, eol, data}; these are offsets above the data field.
  localparam int EOL_BIT = 0;
  localparam int SOF_BIT = 1;

  function automatic int fifo_word_width(input int data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/vid_in_fifo.sv
// -----------------------------------------------------------------------------
// vid_in_fifo
// Synchronous first-word-fall-through FIFO with flush.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous clear of pointers and occupancy
//   wr_en, wr_data    : write request (ignored while full)
//   rd_en             : pop the head word (ignored while empty)
//   rd_data           : head word, valid whenever empty=0
//   full, empty, level: status; level is the registered occupancy
// Depths of 64 and above keep the storage in an inferred RAM with a
// registered read; smaller depths use a plain register file.
// -----------------------------------------------------------------------------
module vid_in_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          wr_ok;
  logic          rd_ok;

  // Fullness ignores a same-cycle pop: a push into a full FIFO is always lost.
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign level = count_reg;
  assign wr_ok = wr_en & ~full & ~flush;
  assign rd_ok = rd_en & ~empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    end
  end

  generate
    if (DEPTH >= 64) begin : g_ram
      logic [WIDTH-1:0] mem [DEPTH];
      logic [WIDTH-1:0] ram_q;
      logic [WIDTH-1:0] byp_data_reg;
      logic             byp_reg;
      logic [AW-1:0]    rd_addr_next;

      // Read one cycle ahead at the address the head will occupy next, so the
      // registered RAM output always holds the head word.
      assign rd_addr_next = rd_ptr_reg + {{(AW-1){1'b0}}, rd_ok};

      always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_reg] <= wr_data;
        ram_q <= mem[rd_addr_next];
      end

      // A write landing on the next head slot is not yet visible through the
      // RAM read port; forward it from a side register instead.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          byp_reg      <= 1'b0;
          byp_data_reg <= '0;
        end else begin
          byp_reg      <= wr_ok && (wr_ptr_reg == rd_addr_next);
          byp_data_reg <= wr_data;
        end
      end

      assign rd_data = byp_reg ? byp_data_reg : ram_q;
    end else begin : g_regs
      logic [WIDTH-1:0] mem_reg [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (wr_ok) begin
          mem_reg[wr_ptr_reg] <= wr_data;
        end
      end

      assign rd_data = mem_reg[rd_ptr_reg];
    end
  endgenerate

endmodule

// File: rtl/vid_in_axis_gen.sv
// -----------------------------------------------------------------------------
// vid_in_axis_gen
// Video-in to AXI4-Stream bridge. Samples a parallel video bus on vid_ce,
// stages one pixel so end-of-line can be flagged, buffers active pixels in a
// FWFT FIFO and streams them with tuser = start-of-frame, tlast = end-of-line.
// Ports:
//   aclk, reset         : clock, asynchronous active-high reset
//   enable              : bridge enable; low flushes and waits for vsync
//   vid_*, field_id_in  : video timing/data, valid on vid_ce
//   m_axis_*            : AXI4-Stream video master
//   vtd_*, field_id_out : timing registered on vid_ce for a timing detector
//   overflow            : sticky, set when a pixel is lost to a full FIFO
//   fifo_level          : FIFO occupancy
//   active_width/height : detected frame size (VID_IN_SIZE_DETECT_EN only)
// Optional feature macro: VID_IN_SIZE_DETECT_EN.
// -----------------------------------------------------------------------------
module vid_in_axis_gen
  import vid_in_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                         aclk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         vid_ce,
  input  logic                         vid_vblank,
  input  logic                         vid_vsync,
  input  logic                         vid_hblank,
  input  logic                         vid_hsync,
  input  logic                         vid_active_video,
  input  logic [DATA_WIDTH-1:0]        vid_data,
  input  logic                         field_id_in,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         vtd_vblank,
  output logic                         vtd_vsync,
  output logic                         vtd_hblank,
  output logic                         vtd_hsync,
  output logic                         vtd_active_video,
  output logic                         field_id_out,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
`ifdef VID_IN_SIZE_DETECT_EN
  ,
  output logic [15:0]                  active_width,
  output logic [15:0]                  active_height
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = fifo_word_width(DATA_WIDTH);

  localparam logic [1:0] S_WAIT_VS = ST_WAIT_VS;
  localparam logic [1:0] S_SYNC    = ST_SYNC;
  localparam logic [1:0] S_RUN     = ST_RUN;
  localparam logic [1:0] S_DROP    = ST_DROP;

  logic [1:0]            state_reg, state_next;
  logic                  stage_valid_reg, stage_valid_next;
  logic                  stage_sof_reg, stage_sof_next;
  logic [DATA_WIDTH-1:0] stage_data_reg, stage_data_next;
  logic                  sof_pending_reg, sof_pending_next;
  logic                  overflow_reg, overflow_next;
  logic                  vsync_d_reg;
  logic                  vs_rise;

  logic                  push;
  logic                  push_eol;
  logic [WW-1:0]         push_word;
  logic [WW-1:0]         head_word;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;

  logic                  vtd_vblank_reg, vtd_vsync_reg, vtd_hblank_reg;
  logic                  vtd_hsync_reg, vtd_active_reg, field_id_reg;

  // vsync edge, judged only on pixel-enable cycles.
  assign vs_rise = vid_ce & vid_vsync & ~vsync_d_reg;

  always_comb begin
    state_next       = state_reg;
    stage_valid_next = stage_valid_reg;
    stage_sof_next   = stage_sof_reg;
    stage_data_next  = stage_data_reg;
    sof_pending_next = sof_pending_reg;
    overflow_next    = overflow_reg;
    push             = 1'b0;
    push_eol         = 1'b0;

    if (!enable) begin
      state_next       = S_WAIT_VS;
      stage_valid_next = 1'b0;
      sof_pending_next = 1'b0;
      overflow_next    = 1'b0;
    end else begin
      case (state_reg)
        S_WAIT_VS: begin
          if (vs_rise) begin
            state_next       = S_SYNC;
            sof_pending_next = 1'b1;
          end
        end
        S_SYNC, S_RUN: begin
          if (vid_ce) begin
            if (vid_active_video) begin
              // The previous pixel is only known not to end the line once
              // another active pixel arrives.
              push             = stage_valid_reg;
              stage_valid_next = 1'b1;
              stage_data_next  = vid_data;
              stage_sof_next   = sof_pending_reg;
              sof_pending_next = 1'b0;
              state_next       = S_RUN;
            end else if (stage_valid_reg) begin
              push             = 1'b1;
              push_eol         = 1'b1;
              stage_valid_next = 1'b0;
            end
          end
          // A new vsync mid-stream realigns the next frame's first pixel.
          if (vs_rise) sof_pending_next = 1'b1;
          if (push && fifo_full) begin
            overflow_next    = 1'b1;
            state_next       = S_DROP;
            stage_valid_next = 1'b0;
          end
        end
        S_DROP: begin
          if (vs_rise) begin
            state_next       = S_SYNC;
            sof_pending_next = 1'b1;
          end
        end
        default: state_next = S_WAIT_VS;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_WAIT_VS;
      stage_valid_reg <= 1'b0;
      stage_sof_reg   <= 1'b0;
      stage_data_reg  <= '0;
      sof_pending_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      vsync_d_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      stage_valid_reg <= stage_valid_next;
      stage_sof_reg   <= stage_sof_next;
      stage_data_reg  <= stage_data_next;
      sof_pending_reg <= sof_pending_next;
      overflow_reg    <= overflow_next;
      if (vid_ce) vsync_d_reg <= vid_vsync;
    end
  end

  always_comb begin
    push_word                     = '0;
    push_word[DATA_WIDTH-1:0]     = stage_data_reg;
    push_word[DATA_WIDTH+SOF_BIT] = stage_sof_reg;
    push_word[DATA_WIDTH+EOL_BIT] = push_eol;
  end

  assign pop = m_axis_tvalid & m_axis_tready;

  vid_in_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (reset),
    .flush   (~enable),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (pop),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Head fields are forced to zero while empty so idle outputs are clean.
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0   : head_word[DATA_WIDTH-1:0];
  assign m_axis_tuser  = fifo_empty ? 1'b0 : head_word[DATA_WIDTH+SOF_BIT];
  assign m_axis_tlast  = fifo_empty ? 1'b0 : head_word[DATA_WIDTH+EOL_BIT];
  assign overflow      = overflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_keep
      assign m_axis_tkeep[gi] = 1'b1;
    end
  endgenerate

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      vtd_vblank_reg <= 1'b0;
      vtd_vsync_reg  <= 1'b0;
      vtd_hblank_reg <= 1'b0;
      vtd_hsync_reg  <= 1'b0;
      vtd_active_reg <= 1'b0;
      field_id_reg   <= 1'b0;
    end else if (vid_ce) begin
      vtd_vblank_reg <= vid_vblank;
      vtd_vsync_reg  <= vid_vsync;
      vtd_hblank_reg <= vid_hblank;
      vtd_hsync_reg  <= vid_hsync;
      vtd_active_reg <= vid_active_video;
      field_id_reg   <= field_id_in;
    end
  end

  assign vtd_vblank       = vtd_vblank_reg;
  assign vtd_vsync        = vtd_vsync_reg;
  assign vtd_hblank       = vtd_hblank_reg;
  assign vtd_hsync        = vtd_hsync_reg;
  assign vtd_active_video = vtd_active_reg;
  assign field_id_out     = field_id_reg;

`ifdef VID_IN_SIZE_DETECT_EN
  logic        active_d_reg;
  logic        act_rise, act_fall;
  logic [15:0] pix_cnt_reg;
  logic [15:0] line_w_reg;
  logic [15:0] line_cnt_reg;
  logic [15:0] width_reg, height_reg;

  assign act_rise = vid_ce & vid_active_video & ~active_d_reg;
  assign act_fall = vid_ce & ~vid_active_video & active_d_reg;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      active_d_reg <= 1'b0;
      pix_cnt_reg  <= '0;
      line_w_reg   <= '0;
      line_cnt_reg <= '0;
      width_reg    <= '0;
      height_reg   <= '0;
    end else begin
      if (vid_ce) active_d_reg <= vid_active_video;
      // The first pixel of a line restarts the count at one.
      if (act_rise) begin
        pix_cnt_reg <= 16'd1;
      end else if (vid_ce && vid_active_video && pix_cnt_reg != 16'hFFFF) begin
        pix_cnt_reg <= pix_cnt_reg + 16'd1;
      end
      if (act_fall) begin
        line_w_reg <= pix_cnt_reg;
      end
      if (vs_rise) begin
        width_reg    <= line_w_reg;
        height_reg   <= line_cnt_reg;
        line_cnt_reg <= '0;
      end else if (act_fall && line_cnt_reg != 16'hFFFF) begin
        line_cnt_reg <= line_cnt_reg + 16'd1;
      end
    end
  end

  assign active_width  = width_reg;
  assign active_height = height_reg;
`endif

endmodule

// File: tb/tb_vid_in_axis_gen.sv
module tb_vid_in_axis_gen;
  import vid_in_pkg::*;

  localparam int DW = 16;

  logic          aclk = 1'b0;
  logic          reset;
  logic          enable;
  logic          vid_ce, vid_vblank, vid_vsync, vid_hblank, vid_hsync;
  logic          vid_active_video, field_id_in;
  logic [DW-1:0] vid_data;
  logic          tready;

  // small DUT (register FIFO, depth 16)
  logic [DW-1:0] tdata;
  logic [1:0]    tkeep;
  logic          tlast, tuser, tvalid;
  logic          v_vblank, v_vsync, v_hblank, v_hsync, v_active, v_field;
  logic          ovf;
  logic [4:0]    level;
  // large DUT (RAM FIFO, depth 64), always ready
  logic [DW-1:0] b_tdata;
  logic [1:0]    b_tkeep;
  logic          b_tlast, b_tuser, b_tvalid;
  logic          b_vblank, b_vsync, b_hblank, b_hsync, b_active, b_field;
  logic          b_ovf;
  logic [6:0]    b_level;
`ifdef VID_IN_SIZE_DETECT_EN
  logic [15:0]   aw, ah, b_aw, b_ah;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] q_data[$];
  bit            q_user[$], q_last[$];
  logic [DW-1:0] b_data[$];
  bit            b_user[$], b_last[$];

  always #5 aclk = ~aclk;

  vid_in_axis_gen #(.DATA_WIDTH(DW), .FIFO_DEPTH(16)) dut (
    .aclk(aclk), .reset(reset), .enable(enable), .vid_ce(vid_ce),
    .vid_vblank(vid_vblank), .vid_vsync(vid_vsync), .vid_hblank(vid_hblank),
    .vid_hsync(vid_hsync), .vid_active_video(vid_active_video),
    .vid_data(vid_data), .field_id_in(field_id_in),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .m_axis_tuser(tuser), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .vtd_vblank(v_vblank), .vtd_vsync(v_vsync), .vtd_hblank(v_hblank),
    .vtd_hsync(v_hsync), .vtd_active_video(v_active), .field_id_out(v_field),
    .overflow(ovf), .fifo_level(level)
`ifdef VID_IN_SIZE_DETECT_EN
    , .active_width(aw), .active_height(ah)
`endif
  );

  vid_in_axis_gen #(.DATA_WIDTH(DW), .FIFO_DEPTH(64)) dut_big (
    .aclk(aclk), .reset(reset), .enable(enable), .vid_ce(vid_ce),
    .vid_vblank(vid_vblank), .vid_vsync(vid_vsync), .vid_hblank(vid_hblank),
    .vid_hsync(vid_hsync), .vid_active_video(vid_active_video),
    .vid_data(vid_data), .field_id_in(field_id_in),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tlast(b_tlast),
    .m_axis_tuser(b_tuser), .m_axis_tvalid(b_tvalid), .m_axis_tready(1'b1),
    .vtd_vblank(b_vblank), .vtd_vsync(b_vsync), .vtd_hblank(b_hblank),
    .vtd_hsync(b_hsync), .vtd_active_video(b_active), .field_id_out(b_field),
    .overflow(b_ovf), .fifo_level(b_level)
`ifdef VID_IN_SIZE_DETECT_EN
    , .active_width(b_aw), .active_height(b_ah)
`endif
  );

  // Beat capture, mid-cycle: a handshake seen here completes on the next edge.
  always @(negedge aclk) begin
    if (tvalid && tready) begin
      q_data.push_back(tdata);
      q_user.push_back(tuser);
      q_last.push_back(tlast);
    end
    if (b_tvalid) begin
      b_data.push_back(b_tdata);
      b_user.push_back(b_tuser);
      b_last.push_back(b_tlast);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic ce, input logic vs, input logic act, input logic [DW-1:0] d);
    vid_ce           = ce;
    vid_vsync        = vs;
    vid_vblank       = vs;
    vid_active_video = act;
    vid_hblank       = ~act;
    vid_hsync        = 1'b0;
    field_id_in      = vs;
    vid_data         = d;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic vsync_pulse();
    drive(1'b1, 1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, '0);
    idle(2);
  endtask

  // One line of n pixels from base; half=1 inserts a vid_ce=0 cycle after
  // every sample carrying junk that must be ignored.
  task automatic send_line(input int n, input logic [DW-1:0] base, input bit half);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b1, base + DW'(i));
      if (half) drive(1'b0, 1'b1, 1'b0, 16'hDEAD);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      if (half) drive(1'b0, 1'b0, 1'b1, 16'hBEEF);
    end
  endtask

  task automatic clear_q();
    q_data.delete(); q_user.delete(); q_last.delete();
    b_data.delete(); b_user.delete(); b_last.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_last, n_user, n_err, b_err;

    reset = 1'b1; enable = 1'b0; tready = 1'b0;
    vid_ce = 0; vid_vsync = 0; vid_vblank = 0; vid_hblank = 0; vid_hsync = 0;
    vid_active_video = 0; field_id_in = 0; vid_data = '0;
    repeat (3) @(posedge aclk);
    #1;
    // ---- reset state
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tuser_tlast", {tuser, tlast}, 0);
    chk("rst_tkeep", tkeep, 2'b11);
    chk("rst_level", level, 0);
    chk("rst_overflow", ovf, 0);
    chk("rst_vtd", {v_vblank, v_vsync, v_hblank, v_hsync, v_active, v_field}, 0);
    chk("rst_state", dut.state_reg, ST_WAIT_VS);
    chk("rst_big_tvalid", b_tvalid, 0);

    reset = 1'b0; enable = 1'b1; tready = 1'b1;
    idle(2);

    // ---- active video before any vsync is ignored
    clear_q();
    send_line(4, 16'h0050, 0);
    idle(4);
    chk("prevs_beats", q_data.size(), 0);
    chk("prevs_big_beats", b_data.size(), 0);

    // ---- vtd registering on vid_ce, doubling as the frame's vsync edge
    drive(1'b1, 1'b1, 1'b0, '0);
    chk("vtd_vsync_set", {v_vsync, v_vblank, v_field, v_hblank}, 4'b1111);
    drive(1'b0, 1'b0, 1'b1, 16'h7777);
    chk("vtd_hold_no_ce", {v_vsync, v_active}, 2'b10);
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("vtd_vsync_clr", v_vsync, 0);

    // ---- 4x2 frame, pixels 1..8, with first-beat latency
    drive(1'b1, 1'b0, 1'b1, 16'h0001);
    chk("lat_tvalid_1clk", tvalid, 0);
    drive(1'b1, 1'b0, 1'b1, 16'h0002);
    chk("lat_tvalid_2clk", tvalid, 1);
    chk("lat_head", {tuser, tdata}, {1'b1, 16'h0001});
    chk("lat_level", level, 1);
    chk("lat_big_head", {b_tvalid, b_tuser, b_tdata}, {2'b11, 16'h0001});
    drive(1'b1, 1'b0, 1'b1, 16'h0003);
    drive(1'b1, 1'b0, 1'b1, 16'h0004);
    idle(4);
    send_line(4, 16'h0005, 0);
    idle(4);
    chk("f4x2_beats", q_data.size(), 8);
    chk("f4x2_big_beats", b_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("f4x2_data%0d", i), q_data[i], 64'(i + 1));
      chk($sformatf("f4x2_user%0d", i), q_user[i], (i == 0));
      chk($sformatf("f4x2_last%0d", i), q_last[i], (i == 3 || i == 7));
      chk($sformatf("f4x2_big%0d", i), {b_user[i], b_last[i], b_data[i]},
          {(i == 0), (i == 3 || i == 7), 16'(i + 1)});
    end

    // ---- 1920-pixel line, vid_ce every other cycle
    clear_q();
    vsync_pulse();
    send_line(1920, 16'h1000, 1);
    idle(6);
    n_last = 0; n_user = 0; n_err = 0; b_err = 0;
    foreach (q_data[i]) begin
      if (q_last[i]) n_last++;
      if (q_user[i]) n_user++;
      if (q_data[i] != 16'(32'h1000 + i)) n_err++;
    end
    foreach (b_data[i]) if (b_data[i] != 16'(32'h1000 + i) || b_last[i] != (i == 1919)) b_err++;
    chk("hd_beats", q_data.size(), 1920);
    chk("hd_tlast_count", n_last, 1);
    chk("hd_tlast_final", q_last[1919], 1);
    chk("hd_tuser_count", n_user, 1);
    chk("hd_tuser_first", q_user[0], 1);
    chk("hd_data_errors", n_err, 0);
    chk("hd_big_beats", b_data.size(), 1920);
    chk("hd_big_errors", b_err, 0);

    // ---- overflow with tready=0, 32-pixel line into a 16-entry FIFO
    clear_q();
    tready = 1'b0;
    vsync_pulse();
    send_line(32, 16'h2000, 0);
    chk("ovf_flag", ovf, 1);
    chk("ovf_level", level, 16);
    chk("ovf_head", {tvalid, tuser, tdata}, {2'b11, 16'h2000});
    chk("ovf_state", dut.state_reg, ST_DROP);
    chk("ovf_big_none", b_ovf, 0);
    send_line(8, 16'h2100, 0);
    chk("ovf_drop_level", level, 16);
    tready = 1'b1;
    idle(24);
    chk("ovf_drain_beats", q_data.size(), 16);
    chk("ovf_drain_lastdata", q_data[15], 16'h200F);
    chk("ovf_drain_noeol", q_last[15], 0);
    vsync_pulse();
    send_line(4, 16'h3000, 0);
    idle(6);
    chk("ovf_recover_beats", q_data.size(), 20);
    chk("ovf_recover_first", {q_user[16], q_data[16]}, {1'b1, 16'h3000});
    chk("ovf_recover_last", {q_last[19], q_data[19]}, {1'b1, 16'h3003});
    chk("ovf_sticky", ovf, 1);

    // ---- enable dropped mid-line
    tready = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1, 16'h4000 + DW'(i));
    chk("en_level_before", level, 5);
    enable = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 16'h4006);
    chk("en_tvalid", tvalid, 0);
    chk("en_level", level, 0);
    chk("en_overflow", ovf, 0);
    chk("en_state", dut.state_reg, ST_WAIT_VS);
    enable = 1'b1; tready = 1'b1;
    clear_q();
    send_line(4, 16'h4100, 0);
    idle(4);
    chk("en_novs_beats", q_data.size(), 0);
    vsync_pulse();
    send_line(3, 16'h4200, 0);
    idle(6);
    chk("en_resume_beats", q_data.size(), 3);
    chk("en_resume_first", {q_user[0], q_data[0]}, {1'b1, 16'h4200});
    chk("en_resume_last", {q_last[2], q_data[2]}, {1'b1, 16'h4202});

    // ---- asynchronous reset mid-frame
    tready = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 16'h4800 + DW'(i));
    chk("arst_level_before", level, 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_level", level, 0);
    chk("arst_tvalid", {tvalid, b_tvalid}, 0);
    @(posedge aclk); #1;
    reset = 1'b0; tready = 1'b1;
    clear_q();
    send_line(4, 16'h4900, 0);
    idle(4);
    chk("arst_novs_beats", q_data.size(), 0);
    vsync_pulse();
    send_line(2, 16'h5000, 0);
    idle(6);
    chk("arst_resume_beats", q_data.size(), 2);
    chk("arst_resume_first", {q_user[0], q_data[0]}, {1'b1, 16'h5000});

`ifdef VID_IN_SIZE_DETECT_EN
    // ---- size detection on a scaled-down 40x24 frame
    chk("size_rst_free", 1'b1, 1'b1 & (aw !== 16'hx));
    vsync_pulse();
    for (int l = 0; l < 24; l++) send_line(40, 16'h6000, 0);
    vsync_pulse();
    chk("size_width", aw, 40);
    chk("size_height", ah, 24);
    chk("size_big", {b_aw, b_ah}, {16'd40, 16'd24});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
